muldiv_unit: RTL

//  Parametrised multi-cycle RV32M/RV64M multiply/divide unit, split out of the ALU datapath.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/result channel between the issuing core and muldiv_unit.
//   I_valid/O_ready      request handshake (issuer -> unit)
//   I_op                 RISC-V funct3 of the M-extension op
//   I_dataS1/I_dataS2    rs1 / rs2 operands
//   I_kill               pipeline flush, abandons the in-flight op
//   O_valid/I_ready      result handshake (unit -> consumer)
//   O_data               result
//   O_busy               unit holds an op that has not retired
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            I_valid;
  logic            O_ready;
  logic [2:0]      I_op;
  logic [XLEN-1:0] I_dataS1;
  logic [XLEN-1:0] I_dataS2;
  logic            I_kill;
  logic            O_valid;
  logic            I_ready;
  logic [XLEN-1:0] O_data;
  logic            O_busy;

  modport master (
    output I_valid, I_op, I_dataS1, I_dataS2, I_kill, I_ready,
    input  O_ready, O_valid, O_data, O_busy
  );

  modport slave (
    input  I_valid, I_op, I_dataS1, I_dataS2, I_kill, I_ready,
    output O_ready, O_valid, O_data, O_busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit.
//   Registered single-cycle multiply, radix-2^DIV_STEP restoring divide,
//   DIV->REM fusion cache holding the last iterated quotient/remainder.
// Ports:
//   I_clk    clock, all state on the rising edge
//   I_reset  synchronous active-high reset
//   bus      muldiv_if slave side (request, kill, result handshakes)
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int DIV_STEP = 1,
  parameter int FUSE_EN  = 1
) (
  input logic     I_clk,
  input logic     I_reset,
  muldiv_if.slave bus
);
  localparam int ITER = XLEN / DIV_STEP;
  localparam int CW   = $clog2(ITER);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state;
  logic [2:0]      op_r;
  logic [XLEN-1:0] s1_r, s2_r;
  logic [XLEN-1:0] div_a, div_p, div_d;   // dividend->quotient, partial remainder, divisor
  logic [CW-1:0]   cnt;
  logic            pre_use;
  logic [XLEN-1:0] pre_res;
  logic            o_valid;
  logic [XLEN-1:0] o_data;

  logic            c_valid, c_sgn;
  logic [XLEN-1:0] c_s1, c_s2, c_quo, c_rem;

  // ---------------- request decode (IDLE only) ----------------
  logic            in_div, in_sgn, in_rem, in_zero, in_ovf, in_hit, in_pre;
  logic [XLEN-1:0] in_mag1, in_mag2, in_pre_res;

  assign in_div  = bus.I_op[2];
  assign in_sgn  = ~bus.I_op[0];
  assign in_rem  = bus.I_op[1];
  assign in_zero = (bus.I_dataS2 == '0);
  assign in_ovf  = in_sgn & (bus.I_dataS1 == MIN_INT) & (&bus.I_dataS2);
  assign in_hit  = (FUSE_EN != 0) & c_valid & (c_s1 == bus.I_dataS1) &
                   (c_s2 == bus.I_dataS2) & (c_sgn == in_sgn);
  assign in_pre  = in_zero | in_ovf | in_hit;
  assign in_mag1 = (in_sgn & bus.I_dataS1[XLEN-1]) ? -bus.I_dataS1 : bus.I_dataS1;
  assign in_mag2 = (in_sgn & bus.I_dataS2[XLEN-1]) ? -bus.I_dataS2 : bus.I_dataS2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_pre_res = '0;
    if (in_zero)     in_pre_res = in_rem ? bus.I_dataS1 : '1;
    else if (in_ovf) in_pre_res = in_rem ? '0 : MIN_INT;
    else             in_pre_res = in_rem ? c_rem : c_quo;
  end

  // ---------------- multiply ----------------
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic [XLEN-1:0]   mul_res;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; MUL's low half is sign-agnostic.
  assign mul_a   = {{XLEN{s1_r[XLEN-1] & (op_r == 3'd1 || op_r == 3'd2)}}, s1_r};
  assign mul_b   = {{XLEN{s2_r[XLEN-1] & (op_r == 3'd1)}}, s2_r};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (op_r == 3'd0) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  // ---------------- divide step: DIV_STEP chained trial subtractions ----------------
  logic [XLEN-1:0] step_a, step_p;
  logic [XLEN:0]   trial;

  always_comb begin
    step_a = div_a;
    step_p = div_p;
    trial  = '0;
    for (int i = 0; i < DIV_STEP; i++) begin
      trial  = {step_p, step_a[XLEN-1]};
      step_a = {step_a[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, div_d}) begin
        trial     = trial - {1'b0, div_d};
        step_a[0] = 1'b1;
      end
      step_p = trial[XLEN-1:0];
    end
  end

  // Sign fix-up of the magnitude result; remainder follows the dividend sign.
  logic [XLEN-1:0] fix_q, fix_r;
  assign fix_q = (~op_r[0] & (s1_r[XLEN-1] ^ s2_r[XLEN-1])) ? -div_a : div_a;
  assign fix_r = (~op_r[0] & s1_r[XLEN-1]) ? -div_p : div_p;

  // ---------------- state ----------------
  // NOTE: only control state and the cache valid bit are reset; datapath and cache
  // payload registers are always written before they are read, so they need no reset.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_data  <= '0;
      c_valid <= 1'b0;
    end else if (bus.I_kill) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      if (state == ST_DIV || state == ST_FIX) c_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.I_valid) begin
          op_r    <= bus.I_op;
          s1_r    <= bus.I_dataS1;
          s2_r    <= bus.I_dataS2;
          pre_use <= in_div & in_pre;
          pre_res <= in_pre_res;
          // Special-case and cache-hit results are resolved now and retire through
          // the one-cycle result stage shared with multiply (same latency).
          if (!in_div || in_pre) begin
            state <= ST_MUL;
          end else begin
            div_a <= in_mag1;
            div_d <= in_mag2;
            div_p <= '0;
            cnt   <= CW'(ITER - 1);
            state <= ST_DIV;
          end
        end
        ST_MUL: begin
          o_data  <= pre_use ? pre_res : mul_res;
          o_valid <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DIV: begin
          div_a <= step_a;
          div_p <= step_p;
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          o_data  <= op_r[1] ? fix_r : fix_q;
          o_valid <= 1'b1;
          c_valid <= 1'b1;
          c_s1    <= s1_r;
          c_s2    <= s2_r;
          c_sgn   <= ~op_r[0];
          c_quo   <= fix_q;
          c_rem   <= fix_r;
          state   <= ST_DONE;
        end
        ST_DONE: if (bus.I_ready) begin
          o_valid <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.O_ready = (state == ST_IDLE);
  assign bus.O_busy  = (state != ST_IDLE);
  assign bus.O_valid = o_valid;
  assign bus.O_data  = o_data;
endmodule
